// File: rtl/tsp16_pkg.sv
// Shared types and defaults for the 16-bit core: data/register sizing,
// register address type and the packed NZV status flag struct.
package tsp16_pkg;

    localparam int DATA_W   = 16;
    localparam int NUM_REGS = 8;
    localparam int ADDR_W   = $clog2(NUM_REGS);

    typedef logic [ADDR_W-1:0] reg_addr_t;

    typedef struct packed {
        logic z;
        logic n;
        logic v;
    } status_flags_t;

    // After reset the core reports "result was zero", not negative, no overflow.
    localparam status_flags_t FLAGS_RESET = '{z: 1'b1, n: 1'b0, v: 1'b0};

endpackage

// File: rtl/status_register.sv
// 3-bit NZV status flag register: loads on we, holds otherwise,
// synchronous active-high reset to FLAGS_RESET.
module status_register
    import tsp16_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          we,
    input  status_flags_t d,
    output status_flags_t q
);

    // Flag storage; reset wins over a same-cycle load.
    always_ff @(posedge clk) begin
        if (rst) begin
            q <= FLAGS_RESET;
        end else if (we) begin
            q <= d;
        end
    end

endmodule

// File: rtl/register_file.sv
// Architectural register file for the 16-bit core.
// Two combinational read ports with write-to-read bypass, one synchronous
// write port, an NZV flag register and a committed-write counter.
// There is no valid/ready handshake here: a write commits on every rising
// edge where wr_en=1 and rst=0, and read data is valid in the same cycle
// the address is presented.
module register_file #(
    parameter  int DATA_W   = tsp16_pkg::DATA_W,
    parameter  int NUM_REGS = tsp16_pkg::NUM_REGS,
    localparam int ADDR_W   = $clog2(NUM_REGS)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] rn_addr,
    input  logic [ADDR_W-1:0] rm_addr,
    output logic [DATA_W-1:0] rn_data,
    output logic [DATA_W-1:0] rm_data,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              flags_we,
    input  logic              z_in,
    input  logic              n_in,
    input  logic              v_in,
    output logic              z,
    output logic              n,
    output logic              v,
    output logic [15:0]       wr_count
);

    import tsp16_pkg::*;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              wr_commit;
    status_flags_t     flags_d;
    status_flags_t     flags_q;

    // A write only takes effect (and only bypasses) when reset is not active.
    assign wr_commit = wr_en && !rst;

    // Register array and write counter; reset clears everything and drops any write.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
            wr_count <= 16'h0000;
        end else if (wr_en) begin
            regs[wr_addr] <= wr_data;
            wr_count      <= wr_count + 16'h0001;
        end
    end

    // Read ports: forward the in-flight write so the reader never sees stale data.
    always_comb begin
        rn_data = regs[rn_addr];
        rm_data = regs[rm_addr];
        if (wr_commit && (wr_addr == rn_addr)) begin
            rn_data = wr_data;
        end
        if (wr_commit && (wr_addr == rm_addr)) begin
            rm_data = wr_data;
        end
    end

    assign flags_d = '{z: z_in, n: n_in, v: v_in};

    status_register u_status (
        .clk (clk),
        .rst (rst),
        .we  (flags_we),
        .d   (flags_d),
        .q   (flags_q)
    );

    // Flags are exposed only from the register; no bypass of the ALU flag inputs.
    assign z = flags_q.z;
    assign n = flags_q.n;
    assign v = flags_q.v;

endmodule

// File: tb/tb_register_file.sv
// Directed bench for register_file. The driver sets inputs just after a
// rising edge and pushes the expected observations into exp_q; a monitor
// on the falling edge pops each entry and compares it with the DUT.
module tb_register_file;

    localparam int DW = 16;
    localparam int AW = 3;

    localparam logic [3:0] K_RN    = 4'd0;
    localparam logic [3:0] K_RM    = 4'd1;
    localparam logic [3:0] K_FLAGS = 4'd2;
    localparam logic [3:0] K_CNT   = 4'd3;

    logic          clk;
    logic          rst;
    logic [AW-1:0] rn_addr;
    logic [AW-1:0] rm_addr;
    logic [DW-1:0] rn_data;
    logic [DW-1:0] rm_data;
    logic          wr_en;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          flags_we;
    logic          z_in;
    logic          n_in;
    logic          v_in;
    logic          z;
    logic          n;
    logic          v;
    logic [15:0]   wr_count;

    // scoreboard: {kind[3:0], value[15:0]}
    logic [19:0] exp_q[$];
    int          tests_run;
    int          tests_failed;
    logic [15:0] exp_cnt;

    register_file dut (
        .clk      (clk),
        .rst      (rst),
        .rn_addr  (rn_addr),
        .rm_addr  (rm_addr),
        .rn_data  (rn_data),
        .rm_data  (rm_data),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .flags_we (flags_we),
        .z_in     (z_in),
        .n_in     (n_in),
        .v_in     (v_in),
        .z        (z),
        .n        (n),
        .v        (v),
        .wr_count (wr_count)
    );

    // clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // driver tasks
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic expect_val(input logic [3:0] kind, input logic [15:0] val);
        exp_q.push_back({kind, val});
    endtask

    task automatic expect_flags(input logic ez, input logic en, input logic ev);
        expect_val(K_FLAGS, {13'd0, ez, en, ev});
    endtask

    task automatic set_read(input logic [AW-1:0] a, input logic [AW-1:0] b);
        rn_addr = a;
        rm_addr = b;
    endtask

    task automatic set_write(input logic en, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wr_en   = en;
        wr_addr = a;
        wr_data = d;
    endtask

    task automatic set_flags(input logic we, input logic iz, input logic in_n, input logic iv);
        flags_we = we;
        z_in     = iz;
        n_in     = in_n;
        v_in     = iv;
    endtask

    // write-count model: advance at every edge that commits a write
    always @(posedge clk) begin
        if (rst) exp_cnt <= 16'h0000;
        else if (wr_en) exp_cnt <= exp_cnt + 16'h0001;
    end

    // monitor: compare every pending expectation against the current outputs
    always @(negedge clk) begin
        while (exp_q.size() > 0) begin
            logic [19:0] item;
            logic [15:0] act;
            string       name;
            item = exp_q.pop_front();
            case (item[19:16])
                K_RN:    begin act = rn_data;              name = "rn_data";  end
                K_RM:    begin act = rm_data;              name = "rm_data";  end
                K_FLAGS: begin act = {13'd0, z, n, v};     name = "flags_znv"; end
                default: begin act = wr_count;             name = "wr_count"; end
            endcase
            tests_run++;
            if (act !== item[15:0]) begin
                tests_failed++;
                $display("FAIL %s at %0t: got 0x%04h expected 0x%04h", name, $time, act, item[15:0]);
            end
        end
    end

    initial begin
        tests_run    = 0;
        tests_failed = 0;
        rst = 1'b1;
        set_read('0, '0);
        set_write(1'b0, '0, '0);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);

        // reset held for two edges
        step();
        step();
        rst = 1'b0;

        // every register reads 0 after reset, flags 1/0/0, counter 0
        for (int i = 0; i < 8; i++) begin
            set_read(AW'(i), AW'(7 - i));
            expect_val(K_RN, 16'h0000);
            expect_val(K_RM, 16'h0000);
            expect_flags(1'b1, 1'b0, 1'b0);
            expect_val(K_CNT, 16'h0000);
            step();
        end

        // basic write then read on both ports
        set_write(1'b1, 3'd3, 16'h1234);
        step();
        set_write(1'b0, 3'd0, 16'h0000);
        set_read(3'd3, 3'd3);
        expect_val(K_RN, 16'h1234);
        expect_val(K_RM, 16'h1234);
        expect_val(K_CNT, 16'h0001);
        step();

        // bypass: r5 holds 0x00AA, overwritten with 0xBEEF while being read
        set_write(1'b1, 3'd5, 16'h00AA);
        step();
        set_write(1'b1, 3'd5, 16'hBEEF);
        set_read(3'd5, 3'd4);
        expect_val(K_RN, 16'hBEEF);
        expect_val(K_RM, 16'h0000);
        expect_val(K_CNT, 16'h0002);
        step();
        set_write(1'b0, 3'd0, 16'h0000);
        set_read(3'd5, 3'd3);
        expect_val(K_RN, 16'hBEEF);
        expect_val(K_RM, 16'h1234);
        expect_val(K_CNT, 16'h0003);
        step();

        // both ports bypass the same in-flight write
        set_write(1'b1, 3'd3, 16'h5555);
        set_read(3'd3, 3'd3);
        expect_val(K_RN, 16'h5555);
        expect_val(K_RM, 16'h5555);
        step();
        set_write(1'b0, 3'd0, 16'h0000);

        // flags load without a register write; no same-cycle flag bypass
        set_flags(1'b1, 1'b0, 1'b1, 1'b1);
        expect_flags(1'b1, 1'b0, 1'b0);
        step();
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        set_read(3'd3, 3'd5);
        expect_flags(1'b0, 1'b1, 1'b1);
        expect_val(K_RN, 16'h5555);
        expect_val(K_RM, 16'hBEEF);
        expect_val(K_CNT, 16'h0004);
        step();

        // register write with flags_we low: flags hold despite new inputs
        set_write(1'b1, 3'd1, 16'h0001);
        set_flags(1'b0, 1'b1, 1'b0, 1'b0);
        step();
        set_write(1'b0, 3'd0, 16'h0000);
        set_read(3'd1, 3'd1);
        expect_flags(1'b0, 1'b1, 1'b1);
        expect_val(K_RN, 16'h0001);
        expect_val(K_CNT, 16'h0005);
        step();

        // register 0 is an ordinary writable register
        set_write(1'b1, 3'd0, 16'hA5A5);
        step();
        set_write(1'b0, 3'd0, 16'h0000);
        set_read(3'd0, 3'd7);
        expect_val(K_RN, 16'hA5A5);
        expect_val(K_RM, 16'h0000);
        expect_val(K_CNT, 16'h0006);
        step();

        // reset priority: write and flag load in the reset cycle are dropped,
        // and the in-flight write is not bypassed while rst is high
        rst = 1'b1;
        set_write(1'b1, 3'd2, 16'hFFFF);
        set_flags(1'b1, 1'b0, 1'b1, 1'b1);
        set_read(3'd2, 3'd3);
        expect_val(K_RN, 16'h0000);
        expect_val(K_RM, 16'h5555);
        step();
        rst = 1'b0;
        set_write(1'b0, 3'd0, 16'h0000);
        set_flags(1'b0, 1'b0, 1'b0, 1'b0);
        set_read(3'd2, 3'd3);
        expect_val(K_RN, 16'h0000);
        expect_val(K_RM, 16'h0000);
        expect_flags(1'b1, 1'b0, 1'b0);
        expect_val(K_CNT, 16'h0000);
        step();

        // counter wrap: 65535 writes reach 0xFFFF, one more wraps to 0
        for (int i = 0; i < 65535; i++) begin
            set_write(1'b1, 3'd6, 16'(i));
            step();
        end
        set_write(1'b0, 3'd0, 16'h0000);
        set_read(3'd6, 3'd6);
        expect_val(K_CNT, 16'hFFFF);
        expect_val(K_RN, 16'hFFFE);
        expect_val(K_CNT, exp_cnt);
        step();
        set_write(1'b1, 3'd6, 16'h7777);
        step();
        set_write(1'b0, 3'd0, 16'h0000);
        expect_val(K_CNT, 16'h0000);
        expect_val(K_RN, 16'h7777);
        step();
        step();

        // everything pushed must have been consumed by the monitor
        tests_run++;
        if (exp_q.size() != 0) begin
            tests_failed++;
            $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
        end

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
